// File: rtl/fetch_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_arbiter
// Round-robin arbiter that lets several state-machine requesters share one
// instruction-memory read port. Host instruction loads pass straight through
// to the memory write port. When the host is writing, no fetch is granted.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   fetch_req        per-requester fetch request (held until granted)
//   fetch_addr       packed per-requester pc, slice i = [ADDR_W*i +: ADDR_W]
//   host_write_en / host_write_addr / host_instr_in   host load port
//   mem_instr_out    combinational read data from instruction memory
//   mem_read_addr    read address to instruction memory
//   mem_write_en / mem_write_addr / mem_write_data    memory write port
//   fetch_grant      one-hot combinational grant for the current cycle
//   instr_out        registered fetched instruction
//   instr_valid      one-hot registered valid, names the owner of instr_out
//   stall_count      (only with PIO_FETCH_PERF_EN) saturating count of cycles
//                    with a pending request but no grant
//
// Configuration macro: PIO_FETCH_PERF_EN enables the stall_count output.
// -----------------------------------------------------------------------------
module fetch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        fetch_req,
    input  logic [NUM_REQ*ADDR_W-1:0] fetch_addr,
    input  logic                      host_write_en,
    input  logic [ADDR_W-1:0]         host_write_addr,
    input  logic [INSTR_W-1:0]        host_instr_in,
    input  logic [INSTR_W-1:0]        mem_instr_out,
    output logic [ADDR_W-1:0]         mem_read_addr,
    output logic                      mem_write_en,
    output logic [ADDR_W-1:0]         mem_write_addr,
    output logic [INSTR_W-1:0]        mem_write_data,
    output logic [NUM_REQ-1:0]        fetch_grant,
`ifdef PIO_FETCH_PERF_EN
    output logic [15:0]               stall_count,
`endif
    output logic [INSTR_W-1:0]        instr_out,
    output logic [NUM_REQ-1:0]        instr_valid
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               any_grant;
    logic [ADDR_W-1:0]  addr_slice [NUM_REQ];

    // Unpack the per-requester program counters.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_slice[gi] = fetch_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Host writes are a pure pass-through to the memory write port.
    assign mem_write_en   = host_write_en;
    assign mem_write_addr = host_write_addr;
    assign mem_write_data = host_instr_in;

    // Round-robin scan starting at rr_ptr. grant_idx falls back to rr_ptr
    // when nothing is granted so the read address stays well defined.
    // Reset is folded in so the grant is suppressed while rst is held.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_idx = rr_ptr;
        any_grant = 1'b0;
        idx       = rr_ptr;
        if (!rst && !host_write_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = rr_ptr + PTR_W'(k);
                if (!any_grant && fetch_req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    any_grant  = 1'b1;
                end
            end
        end
    end

    assign fetch_grant   = grant;
    assign mem_read_addr = addr_slice[grant_idx];

    // Memory read is combinational, so the fetched word is captured at the
    // end of the grant cycle and presented with a one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            instr_out   <= '0;
            instr_valid <= '0;
        end else if (any_grant) begin
            rr_ptr      <= grant_idx + PTR_W'(1);
            instr_out   <= mem_instr_out;
            instr_valid <= grant;
        end else begin
            instr_valid <= '0;
        end
    end

`ifdef PIO_FETCH_PERF_EN
    // Counts cycles where someone wanted the port but was blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((fetch_req != '0) && !any_grant && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fetch_arbiter
// Self-checking bench for fetch_arbiter. Provides the instruction memory,
// drives directed and random traffic, and compares every cycle against a
// reference model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_fetch_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int IW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     fetch_req;
    logic [NR*AW-1:0]  fetch_addr;
    logic              host_write_en;
    logic [AW-1:0]     host_write_addr;
    logic [IW-1:0]     host_instr_in;
    logic [IW-1:0]     mem_instr_out;
    logic [AW-1:0]     mem_read_addr;
    logic              mem_write_en;
    logic [AW-1:0]     mem_write_addr;
    logic [IW-1:0]     mem_write_data;
    logic [NR-1:0]     fetch_grant;
    logic [IW-1:0]     instr_out;
    logic [NR-1:0]     instr_valid;
`ifdef PIO_FETCH_PERF_EN
    logic [15:0]       stall_count;
`endif

    always #5 clk = ~clk;

    fetch_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .host_write_en   (host_write_en),
        .host_write_addr (host_write_addr),
        .host_instr_in   (host_instr_in),
        .mem_instr_out   (mem_instr_out),
        .mem_read_addr   (mem_read_addr),
        .mem_write_en    (mem_write_en),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .fetch_grant     (fetch_grant),
`ifdef PIO_FETCH_PERF_EN
        .stall_count     (stall_count),
`endif
        .instr_out       (instr_out),
        .instr_valid     (instr_valid)
    );

    // Instruction memory seen by the DUT: combinational read, clocked write.
    logic [IW-1:0] mem [32];
    assign mem_instr_out = mem[mem_read_addr];
    always @(posedge clk) if (mem_write_en) mem[mem_write_addr] <= mem_write_data;

    // Reference model state.
    int            m_ptr;
    logic [NR-1:0] m_valid;
    logic [IW-1:0] m_instr;
    logic [IW-1:0] ref_mem [32];
    int            m_stall;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: compute expectations from the current inputs, check at
    // the falling edge, then advance the model across the rising edge.
    task automatic cycle_step();
        int            w;
        logic [NR-1:0] exp_grant;
        logic [AW-1:0] exp_raddr;
        if (rst) begin
            m_ptr = 0; m_valid = '0; m_instr = '0; m_stall = 0;
        end
        w = -1;
        if (!rst && !host_write_en) begin
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && fetch_req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
        end
        exp_grant = (w >= 0) ? NR'(1 << w) : '0;
        exp_raddr = fetch_addr[((w >= 0) ? w : m_ptr)*AW +: AW];
        @(negedge clk);
        check("grant", 64'(fetch_grant), 64'(exp_grant));
        check("raddr", 64'(mem_read_addr), 64'(exp_raddr));
        check("valid", 64'(instr_valid), 64'(m_valid));
        check("instr", 64'(instr_out), 64'(m_instr));
        check("wport", {mem_write_en, mem_write_addr, mem_write_data},
              {host_write_en, host_write_addr, host_instr_in});
`ifdef PIO_FETCH_PERF_EN
        check("stall", 64'(stall_count), 64'(m_stall));
`endif
        $display("cyc t=%0t rst=%0b req=%b hw=%0b grant=%b valid=%b instr=%h",
                 $time, rst, fetch_req, host_write_en, fetch_grant, instr_valid, instr_out);
        @(posedge clk);
        if (!rst) begin
            if (w >= 0) begin
                m_ptr   = (w + 1) % NR;
                m_instr = ref_mem[fetch_addr[w*AW +: AW]];
                m_valid = NR'(1 << w);
            end else begin
                m_valid = '0;
            end
            if (fetch_req != '0 && w < 0 && m_stall < 65535) m_stall++;
        end
        if (host_write_en) ref_mem[host_write_addr] = host_instr_in;
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = '0; host_write_en = 1'b0;
        host_write_addr = '0; host_instr_in = '0;
    endtask

    initial begin
        logic [3:0] rr_seq [8];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 32; i++) begin
            mem[i] = IW'($urandom);
            ref_mem[i] = mem[i];
        end
        m_ptr = 0; m_valid = '0; m_instr = '0; m_stall = 0;
        rst = 1'b1;
        idle_inputs();
        fetch_addr = '0;
        // Grant must stay clear under reset even with every request raised.
        fetch_req = 4'b1111;
        #1;
        cycle_step();
        cycle_step();
        rst = 1'b0;
        idle_inputs();

        // Host load of A5A5 at address 3, then requester 0 fetches it.
        host_write_en = 1'b1; host_write_addr = 5'd3; host_instr_in = 16'hA5A5;
        cycle_step();
        idle_inputs();
        fetch_req = 4'b0001; fetch_addr[0 +: AW] = 5'd3;
        cycle_step();
        check("dir_a5a5", {44'd0, instr_valid, instr_out}, {44'd0, 4'b0001, 16'hA5A5});

        // All four requesting from rr_ptr=0 rotate once each per 4 cycles.
        rst = 1'b1; idle_inputs(); cycle_step(); rst = 1'b0;
        fetch_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 check("dir_rr", 64'(fetch_grant), 64'(rr_seq[i]));
            cycle_step();
        end

        // Host write blocks a grant; rotation resumes from the held pointer.
        idle_inputs();
        fetch_req = 4'b0110;
        cycle_step();
        host_write_en = 1'b1; host_write_addr = 5'd9; host_instr_in = 16'hBEEF;
        cycle_step();
        host_write_en = 1'b0;
        cycle_step();
        cycle_step();

        // Write address 7 then immediately fetch it.
        idle_inputs();
        host_write_en = 1'b1; host_write_addr = 5'd7; host_instr_in = 16'h1234;
        cycle_step();
        idle_inputs();
        fetch_req = 4'b0001; fetch_addr[0 +: AW] = 5'd7;
        cycle_step();
        check("dir_1234", {44'd0, instr_valid, instr_out}, {44'd0, 4'b0001, 16'h1234});

        // Reset pulsed in a cycle that would grant requester 2.
        idle_inputs();
        fetch_req = 4'b0100;
        cycle_step();
        rst = 1'b1;
        cycle_step();
        rst = 1'b0;
        fetch_req = 4'b0000;
        cycle_step();
        fetch_req = 4'b1111;
        #1 check("dir_rst_ptr", 64'(fetch_grant), 64'(4'b0001));
        cycle_step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            fetch_req       = NR'($urandom);
            fetch_addr      = (NR*AW)'($urandom);
            host_write_en   = ($urandom_range(0, 4) == 0);
            host_write_addr = AW'($urandom);
            host_instr_in   = IW'($urandom);
            rst             = ($urandom_range(0, 99) == 0);
            cycle_step();
        end
        rst = 1'b0;

`ifdef PIO_FETCH_PERF_EN
        rst = 1'b1; idle_inputs(); cycle_step(); rst = 1'b0;
        fetch_req = 4'b0001; host_write_en = 1'b1;
        for (int i = 0; i < 5; i++) cycle_step();
        check("dir_stall5", 64'(stall_count), 64'd5);
        for (int i = 0; i < 65540; i++) cycle_step();
        check("dir_stall_sat", 64'(stall_count), 64'hFFFF);
        idle_inputs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
